branch_unit: RTL and testbench

- Parametrised next-generation branch decision block for the RV32I core; sits between decode/execute and fetch.
- Evaluates the 3-bit branch condition on XLEN-bit operands, using the existing op encoding.
- Adds a direction predictor, a bimodal table of saturating counters indexed by PC, looked up at fetch and trained at resolve.
- Registers the resolved outcome and a mispredict flag for the PC-redirect logic, and keeps branch/mispredict statistics counters.

---
 rtl/branch_unit.sv | 120 ++++++++++++
 tb/tb_branch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Branch decision unit: resolves the branch condition, registers the outcome
// and mispredict flag, and owns a bimodal predictor of saturating counters
// that is looked up at fetch and trained at resolve.
module branch_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_BITS    = 2,
   parameter int STAT_BITS   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [XLEN-1:0]      lk_pc,
   output logic                 lk_taken,
   input  logic                 res_valid,
   input  logic [XLEN-1:0]      res_pc,
   input  logic [XLEN-1:0]      res_in1,
   input  logic [XLEN-1:0]      res_in2,
   input  logic [2:0]           res_op,
   input  logic                 res_pred,
   input  logic                 flush,
   output logic                 out_valid,
   output logic                 out_taken,
   output logic                 out_mispredict,
   output logic [STAT_BITS-1:0] stat_branches,
   output logic [STAT_BITS-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   // Weakly not-taken: MSB clear, every lower bit set.
   localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

   logic [BHT_ENTRIES-1:0][CNT_BITS-1:0] bht_q, bht_d;
   logic [STAT_BITS-1:0] stat_br_q, stat_br_d;
   logic [STAT_BITS-1:0] stat_mp_q, stat_mp_d;
   logic                 out_valid_q, out_taken_q, out_misp_q;

   logic [IDX_W-1:0]    lk_idx, res_idx;
   logic [CNT_BITS-1:0] lk_cnt, res_cnt;
   logic                cond;
   logic                fire;
   logic                is_cond_br;
   logic                train;
   logic                mispred;

   // PC bits outside the index field never influence the table.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0],
                             res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

   assign lk_idx   = lk_pc[IDX_W+1:2];
   assign res_idx  = res_pc[IDX_W+1:2];
   assign lk_cnt   = bht_q[lk_idx];
   assign res_cnt  = bht_q[res_idx];
   // Lookup reads the registered table, so a same-cycle update is not bypassed.
   assign lk_taken = lk_cnt[CNT_BITS-1];

   assign fire       = res_valid & ~flush;
   assign is_cond_br = (res_op[2:1] != 2'b01);   // 010/011 are jump/never
   assign train      = fire & is_cond_br;
   assign mispred    = cond ^ res_pred;

   // Branch condition evaluation over the full operand width.
   always_comb begin
      cond = 1'b0;
      case (res_op)
         3'b000: cond = (res_in1 == res_in2);
         3'b001: cond = (res_in1 != res_in2);
         3'b010: cond = 1'b1;
         3'b011: cond = 1'b0;
         3'b100: cond = ($signed(res_in1) <  $signed(res_in2));
         3'b101: cond = ($signed(res_in1) >= $signed(res_in2));
         3'b110: cond = (res_in1 <  res_in2);
         3'b111: cond = (res_in1 >= res_in2);
         default: cond = 1'b0;
      endcase
   end

   // Next-state for predictor training and saturating statistics.
   always_comb begin
      bht_d     = bht_q;
      stat_br_d = stat_br_q;
      stat_mp_d = stat_mp_q;
      if (train) begin
         if (cond) begin
            if (res_cnt != CNT_MAX) bht_d[res_idx] = res_cnt + CNT_BITS'(1);
         end else begin
            if (res_cnt != '0) bht_d[res_idx] = res_cnt - CNT_BITS'(1);
         end
         if (stat_br_q != '1) stat_br_d = stat_br_q + STAT_BITS'(1);
         if (mispred && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + STAT_BITS'(1);
      end
   end

   // State registers; result registers clear whenever nothing is resolved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bht_q       <= {BHT_ENTRIES{CNT_INIT}};
         stat_br_q   <= '0;
         stat_mp_q   <= '0;
         out_valid_q <= 1'b0;
         out_taken_q <= 1'b0;
         out_misp_q  <= 1'b0;
      end else begin
         bht_q       <= bht_d;
         stat_br_q   <= stat_br_d;
         stat_mp_q   <= stat_mp_d;
         out_valid_q <= fire;
         out_taken_q <= fire & cond;
         out_misp_q  <= fire & mispred;
      end
   end

   assign out_valid        = out_valid_q;
   assign out_taken        = out_taken_q;
   assign out_mispredict   = out_misp_q;
   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: the stimulus process updates a simple
// counter-array model and queues the expected registered result; a monitor
// on the falling edge pops and compares.
module tb_branch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] lk_pc;
   logic        lk_taken;
   logic        res_valid;
   logic [31:0] res_pc, res_in1, res_in2;
   logic [2:0]  res_op;
   logic        res_pred;
   logic        flush;
   logic        out_valid, out_taken, out_mispredict;
   logic [31:0] stat_branches, stat_mispredicts;

   branch_unit dut (
      .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_taken(lk_taken),
      .res_valid(res_valid), .res_pc(res_pc), .res_in1(res_in1),
      .res_in2(res_in2), .res_op(res_op), .res_pred(res_pred), .flush(flush),
      .out_valid(out_valid), .out_taken(out_taken),
      .out_mispredict(out_mispredict), .stat_branches(stat_branches),
      .stat_mispredicts(stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        t;
      logic        m;
      logic [31:0] sb;
      logic [31:0] sm;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;

   // Reference model: 64 two-bit counters and two saturating tallies.
   int          bht[64];
   longint      m_sb, m_sm;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic logic model_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd2: return 1'b1;
         3'd3: return 1'b0;
         3'd4: return $signed(a) <  $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a <  b;
         default: return a >= b;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) bht[i] = 1;
      m_sb = 0;
      m_sm = 0;
   endtask

   // Drive one cycle of stimulus, check the combinational lookup against the
   // pre-update model, then queue the expected registered outcome.
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op, input logic pred,
                       input logic fl, input logic [31:0] lpc);
      exp_t e;
      logic c, go;
      int   k;
      @(negedge clk); #1;
      res_valid = v; res_pc = pc; res_in1 = a; res_in2 = b;
      res_op = op; res_pred = pred; flush = fl; lk_pc = lpc;
      #1;
      chk("lk_taken", lk_taken, bht[idx_of(lpc)] >= 2);
      c  = model_cond(op, a, b);
      go = v && !fl;
      e.v = go;
      e.t = go && c;
      e.m = go && (c != pred);
      if (go && op != 3'd2 && op != 3'd3) begin
         k = idx_of(pc);
         if (c) bht[k] = (bht[k] == 3) ? 3 : bht[k] + 1;
         else   bht[k] = (bht[k] == 0) ? 0 : bht[k] - 1;
         if (m_sb < 64'hFFFF_FFFF) m_sb++;
         if (c != pred && m_sm < 64'hFFFF_FFFF) m_sm++;
      end
      e.sb = m_sb[31:0];
      e.sm = m_sm[31:0];
      q.push_back(e);
   endtask

   task automatic idle(input logic [31:0] lpc);
      step(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, lpc);
   endtask

   // Monitor: every falling edge with an outstanding expectation is compared.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && q.size() > 0) begin
         e = q.pop_front();
         chk("out_valid", out_valid, e.v);
         chk("out_taken", out_taken, e.t);
         chk("out_mispredict", out_mispredict, e.m);
         chk("stat_branches", stat_branches, e.sb);
         chk("stat_mispredicts", stat_mispredicts, e.sm);
      end
   end

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 4))
         0: return 32'hFFFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'h7FFF_FFFF;
         3: return 32'($urandom_range(0, 3));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] pcs [4];
      logic [31:0] a;
      pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104; pcs[3] = 32'h3FC;
      model_reset();
      rst_n = 1'b0; res_valid = 1'b0; res_pc = '0; res_in1 = '0; res_in2 = '0;
      res_op = '0; res_pred = 1'b0; flush = 1'b0; lk_pc = 32'h100;
      #2;
      chk("reset lk_taken", lk_taken, 1'b0);
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset stat_branches", stat_branches, 32'd0);
      @(negedge clk); @(negedge clk); #1;
      rst_n = 1'b1;

      repeat (5) idle(32'h100);

      // Signed LT taken against a not-taken prediction.
      step(1'b1, 32'h100, 32'hFFFF_FFFF, 32'd1, 3'd4, 1'b0, 1'b0, 32'h100);
      idle(32'h100);
      // Unsigned LT taken four times: saturate, then two not-taken.
      repeat (4) step(1'b1, 32'h100, 32'd1, 32'hFFFF_FFFF, 3'd6, 1'b1, 1'b0, 32'h100);
      repeat (2) step(1'b1, 32'h100, 32'hFFFF_FFFF, 32'd1, 3'd6, 1'b1, 1'b0, 32'h100);
      idle(32'h100);
      // Jump and never-taken: outputs only.
      step(1'b1, 32'h100, 32'd0, 32'd0, 3'd2, 1'b1, 1'b0, 32'h100);
      step(1'b1, 32'h100, 32'd0, 32'd0, 3'd3, 1'b1, 1'b0, 32'h100);
      // Flushed resolve.
      step(1'b1, 32'h100, 32'd5, 32'd5, 3'd0, 1'b0, 1'b1, 32'h100);
      // Aliased PCs, lookup of the index being trained in the same cycle.
      step(1'b1, 32'h200, 32'd5, 32'd5, 3'd0, 1'b0, 1'b0, 32'h100);
      step(1'b1, 32'h100, 32'd5, 32'd5, 3'd0, 1'b0, 1'b0, 32'h200);
      idle(32'h200);

      // Randomised traffic over a few aliasing and distinct PCs.
      for (int n = 0; n < 400; n++) begin
         a = rand_opnd();
         step($urandom_range(0, 9) < 8, pcs[$urandom_range(0, 3)], a,
              ($urandom_range(0, 3) == 0) ? a : rand_opnd(),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) == 0, pcs[$urandom_range(0, 3)]);
      end

      // Mid-stream reset with a resolve pending on the inputs.
      step(1'b1, 32'h100, 32'd5, 32'd5, 3'd0, 1'b1, 1'b0, 32'h100);
      idle(32'h100);
      @(negedge clk); #2;
      res_valid = 1'b1; res_op = 3'd2; res_pc = 32'h100; flush = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid-reset out_valid", out_valid, 1'b0);
      chk("mid-reset out_taken", out_taken, 1'b0);
      chk("mid-reset stat_branches", stat_branches, 32'd0);
      chk("mid-reset stat_mispredicts", stat_mispredicts, 32'd0);
      chk("mid-reset lk_taken", lk_taken, 1'b0);
      @(negedge clk); #1;
      chk("reset hold out_valid", out_valid, 1'b0);
      q.delete();
      rst_n = 1'b1;
      step(1'b1, 32'h100, 32'd3, 32'd4, 3'd4, 1'b0, 1'b0, 32'h100);
      idle(32'h100);

      repeat (3) @(negedge clk);
      chk("scoreboard drained", q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
